// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, shifter operation kinds, flag payload.
package alu_pkg;

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SHL = 6'b000000;

   typedef enum logic [1:0] {
      SH_SRL = 2'd0,
      SH_SRA = 2'd1,
      SH_SHL = 2'd2
   } shift_kind_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SRL/SRA/SHL; amounts >= width saturate to the fully-shifted value.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] amt,
   input  shift_kind_e      kind,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH:0]          amt_ext;
   logic                    sat;
   logic signed [WIDTH-1:0] sra_raw;

   // One extra bit so the width itself is representable for the saturation compare.
   assign amt_ext = {1'b0, amt};
   assign sat     = (amt_ext >= (WIDTH+1)'(WIDTH));

   // Kept in its own signed net so the arithmetic shift is not demoted by unsigned context.
   assign sra_raw = $signed(a) >>> amt;

   // Select the requested shift, substituting the saturated value for large amounts.
   always_comb begin
      result = '0;
      case (kind)
         SH_SRL:  result = sat ? '0 : (a >> amt);
         SH_SRA:  result = sat ? {WIDTH{a[WIDTH-1]}} : $unsigned(sra_raw);
         SH_SHL:  result = sat ? '0 : (a << amt);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// ALU top: combinational result plus registered Z/N/C/V flags.
// Optional logical left shift on OP 000000 is enabled by defining ALU_SHL_EN.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned MAXTAM = 8,
   parameter int unsigned OPCODE = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MAXTAM-1:0] A,
   input  logic [MAXTAM-1:0] B,
   input  logic [OPCODE-1:0] OP,
   output logic [MAXTAM-1:0] ALU_Result,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c,
   output logic              flag_v
);

   localparam int unsigned MSB = MAXTAM - 1;

   logic [MAXTAM:0]   sum;
   logic [MAXTAM:0]   diff;
   logic [MAXTAM-1:0] shift_res;
   shift_kind_e       shift_kind;
   logic              carry_c;
   logic              ovf_c;
   alu_flags_t        flags_q;

   // Extended add/sub: top bit is carry-out, or borrow (A < B unsigned) for subtraction.
   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = {1'b0, A} - {1'b0, B};

   // Map the opcode onto the shifter's operation kind.
   always_comb begin
      shift_kind = SH_SRL;
      if (OP == OPCODE'(OP_SRA)) begin
         shift_kind = SH_SRA;
      end
`ifdef ALU_SHL_EN
      else if (OP == OPCODE'(OP_SHL)) begin
         shift_kind = SH_SHL;
      end
`endif
   end

   alu_shifter #(
      .WIDTH (MAXTAM)
   ) u_shifter (
      .a      (A),
      .amt    (B),
      .kind   (shift_kind),
      .result (shift_res)
   );

   // Result select with carry/overflow for the arithmetic ops; unknown opcodes give zero.
   always_comb begin
      ALU_Result = '0;
      carry_c    = 1'b0;
      ovf_c      = 1'b0;
      case (OP)
         OPCODE'(OP_ADD): begin
            ALU_Result = sum[MSB:0];
            carry_c    = sum[MAXTAM];
            ovf_c      = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
         end
         OPCODE'(OP_SUB): begin
            ALU_Result = diff[MSB:0];
            carry_c    = diff[MAXTAM];
            ovf_c      = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
         end
         OPCODE'(OP_AND): ALU_Result = A & B;
         OPCODE'(OP_OR):  ALU_Result = A | B;
         OPCODE'(OP_XOR): ALU_Result = A ^ B;
         OPCODE'(OP_NOR): ALU_Result = ~(A | B);
         OPCODE'(OP_SRL): ALU_Result = shift_res;
         OPCODE'(OP_SRA): ALU_Result = shift_res;
`ifdef ALU_SHL_EN
         OPCODE'(OP_SHL): ALU_Result = shift_res;
`endif
         default: ALU_Result = '0;
      endcase
   end

   // Flag register: captures the status of the operands present at each rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else begin
         flags_q.z <= (ALU_Result == '0);
         flags_q.n <= ALU_Result[MSB];
         flags_q.c <= carry_c;
         flags_q.v <= ovf_c;
      end
   end

   assign flag_z = flags_q.z;
   assign flag_n = flags_q.n;
   assign flag_c = flags_q.c;
   assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (MAXTAM=8, OPCODE=6): directed literal cases plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_alu;

   logic       clk;
   logic       rst_n;
   logic [7:0] A;
   logic [7:0] B;
   logic [5:0] OP;
   logic [7:0] ALU_Result;
   logic       flag_z, flag_n, flag_c, flag_v;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_flags;

   alu #(.MAXTAM(8), .OPCODE(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (A),
      .B          (B),
      .OP         (OP),
      .ALU_Result (ALU_Result),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .flag_c     (flag_c),
      .flag_v     (flag_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_signed8(int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   // Reference result from plain integer arithmetic.
   function automatic int exp_res(int a, int b, int op);
      int sa;
      int p;
      sa = to_signed8(a);
      case (op)
         'h20: return (a + b) % 256;
         'h22: return (a - b + 256) % 256;
         'h24: return a & b;
         'h25: return a | b;
         'h26: return a ^ b;
         'h27: return 255 - (a | b);
         'h02: begin
            if (b >= 8) return 0;
            p = 1 << b;
            return a / p;
         end
         'h03: begin
            if (b >= 8) return (sa < 0) ? 255 : 0;
            p = 1 << b;
            if (sa < 0) return (-((-sa + p - 1) / p)) & 255;
            return sa / p;
         end
`ifdef ALU_SHL_EN
         'h00: begin
            if (b >= 8) return 0;
            p = 1 << b;
            return (a * p) % 256;
         end
`endif
         default: return 0;
      endcase
   endfunction

   // Reference flags {z,n,c,v} from integer ranges.
   function automatic logic [3:0] exp_flag_vec(int a, int b, int op);
      int r;
      int s;
      logic c, v;
      r = exp_res(a, b, op);
      c = 1'b0;
      v = 1'b0;
      if (op == 'h20) begin
         c = (a + b) > 255;
         s = to_signed8(a) + to_signed8(b);
         v = (s > 127) || (s < -128);
      end else if (op == 'h22) begin
         c = a < b;
         s = to_signed8(a) - to_signed8(b);
         v = (s > 127) || (s < -128);
      end
      return {(r == 0), (r >= 128), c, v};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the flag state: sampled at each rising edge, cleared asynchronously.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_flags <= 4'b0000;
      else        exp_flags <= exp_flag_vec(int'(A), int'(B), int'(OP));
   end

   // Every-cycle comparison, away from the rising edge.
   always @(negedge clk) begin
      check("cmp_result", int'(ALU_Result), exp_res(int'(A), int'(B), int'(OP)));
      check("cmp_flags", int'({flag_z, flag_n, flag_c, flag_v}), int'(exp_flags));
   end

   task automatic drive(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
      OP = op;
      A  = a;
      B  = b;
   endtask

   // Apply one operation, check the literal result now and the literal flags after the edge.
   task automatic directed(input string name, input logic [5:0] op, input logic [7:0] a,
                           input logic [7:0] b, input int res, input int flags);
      drive(op, a, b);
      #1;
      check({name, "_res"}, int'(ALU_Result), res);
      @(posedge clk);
      #1;
      check({name, "_flags"}, int'({flag_z, flag_n, flag_c, flag_v}), flags);
   endtask

   logic [5:0] op_tab [10];

   initial begin
      op_tab[0] = 6'h20; op_tab[1] = 6'h22; op_tab[2] = 6'h24; op_tab[3] = 6'h25;
      op_tab[4] = 6'h26; op_tab[5] = 6'h27; op_tab[6] = 6'h02; op_tab[7] = 6'h03;
      op_tab[8] = 6'h00; op_tab[9] = 6'h3F;

      rst_n = 1'b0;
      drive(6'h20, 8'd0, 8'd0);
      #2;
      check("reset_flags", int'({flag_z, flag_n, flag_c, flag_v}), 0);
      @(posedge clk);
      #1;
      check("reset_hold", int'({flag_z, flag_n, flag_c, flag_v}), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Flag vector order is {z,n,c,v}.
      directed("add_carry",  6'h20, 8'd200, 8'd100, 44,    4'b0010);
      directed("add_ovf",    6'h20, 8'h7F,  8'h01,  'h80,  4'b0101);
      directed("sub_borrow", 6'h22, 8'd5,   8'd10,  251,   4'b0110);
      directed("sub_zero",   6'h22, 8'd10,  8'd10,  0,     4'b1000);
      directed("and",        6'h24, 8'h0F,  8'h3C,  'h0C,  4'b0000);
      directed("or",         6'h25, 8'h0F,  8'h3C,  'h3F,  4'b0000);
      directed("xor",        6'h26, 8'h0F,  8'h3C,  'h33,  4'b0000);
      directed("nor",        6'h27, 8'h0F,  8'h3C,  'hC0,  4'b0100);
      directed("bad_op",     6'h3F, 8'h0F,  8'h3C,  'h00,  4'b1000);
      directed("sra_2",      6'h03, 8'h90,  8'd2,   'hE4,  4'b0100);
      directed("sra_10",     6'h03, 8'h90,  8'd10,  'hFF,  4'b0100);
      directed("srl_2",      6'h02, 8'h90,  8'd2,   'h24,  4'b0000);
      directed("srl_10",     6'h02, 8'h90,  8'd10,  'h00,  4'b1000);
`ifdef ALU_SHL_EN
      directed("shl_3",      6'h00, 8'h13,  8'd3,   'h98,  4'b0100);
      directed("shl_8",      6'h00, 8'h13,  8'd8,   'h00,  4'b1000);
`else
      directed("op0_off",    6'h00, 8'h13,  8'd3,   'h00,  4'b1000);
`endif

      // Mid-cycle reset after an overflowing add.
      directed("pre_rst",    6'h20, 8'h7F,  8'h01,  'h80,  4'b0101);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_flags", int'({flag_z, flag_n, flag_c, flag_v}), 0);
      check("rst_result", int'(ALU_Result), 'h80);
      @(posedge clk);
      #1;
      check("rst_low_flags", int'({flag_z, flag_n, flag_c, flag_v}), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_resume_flags", int'({flag_z, flag_n, flag_c, flag_v}), 'b0101);

      // Randomized traffic; the per-cycle compare process checks it.
      repeat (400) begin
         @(posedge clk);
         #1;
         OP = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 9)];
         A  = 8'($urandom);
         B  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter MAXTAM, default 8, data width of A, B and ALU_Result.
REQ-002 SHALL have parameter OPCODE, default 6, width of OP.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port A, input, MAXTAM, first operand; also the value being shifted.
REQ-006 SHALL have port B, input, MAXTAM, second operand; also the shift amount.
REQ-007 SHALL have port OP, input, OPCODE, operation select.
REQ-008 SHALL have port ALU_Result, output, MAXTAM, combinational result.
REQ-009 SHALL have ports flag_z, flag_n, flag_c, flag_v, output, 1 each, registered zero, negative, carry/borrow and signed-overflow flags.

Function
REQ-010 SHALL drive ALU_Result combinationally from A, B and OP (zero latency, no clock dependence), as follows:
- 100000: A+B, mod 2^MAXTAM.
- 100010: A-B, mod 2^MAXTAM.
- 100100: A&B.
- 100101: A|B.
- 100110: A^B.
- 100111: ~(A|B).
- 000010: logical right shift of A by B.
- 000011: arithmetic right shift of A by B; vacated bits take A[MAXTAM-1].
REQ-011 SHALL use the full unsigned value of B as the shift amount; for an amount >= MAXTAM, SRL yields all zeros and SRA yields all copies of A[MAXTAM-1].
REQ-012 SHALL drive ALU_Result to all zeros for any unrecognised OP.
REQ-013 SHALL load flag_z with (ALU_Result==0) and flag_n with ALU_Result[MAXTAM-1] on every rising clk edge, for every OP.
REQ-014 SHALL load flag_c with the carry-out on ADD and with the borrow (A<B, unsigned) on SUB, and with 0 for all other OP.
REQ-015 SHALL load flag_v with two's-complement signed overflow on ADD/SUB, and with 0 for all other OP.
REQ-016 SHALL make the flags reflect the A/B/OP values sampled at that edge (one-cycle latency); there is no handshake or enable.

Reset
REQ-017 SHALL clear all four flags to 0 immediately on rst_n low, independent of clk.
REQ-018 SHALL keep the flags at 0 while rst_n is low.
REQ-019 SHALL resume flag updates on the first rising clk edge after rst_n returns high.
REQ-020 SHALL leave ALU_Result unaffected by reset (purely combinational).

Configuration
REQ-021 SHALL, when macro ALU_SHL_EN is defined, implement OP 000000 as a logical left shift of A by B (amount >= MAXTAM yields 0), with flag_c=flag_v=0.
REQ-022 SHALL, when ALU_SHL_EN is undefined, treat OP 000000 as unrecognised (ALU_Result=0).

Structure
REQ-023 SHALL place all opcode constants (ADD, SUB, AND, OR, XOR, NOR, SRL, SRA, SHL) in a shared package alu_pkg.
REQ-024 SHALL implement the shift logic (SRL/SRA/SHL, amount saturation) in one sub-module, alu_shifter, instantiated by alu.
REQ-025 SHALL implement result selection and the flag register directly in alu.

Verification
REQ-026 SHALL cover: ADD, A=200, B=100 -> ALU_Result=44; after the edge flag_c=1, flag_v=0, flag_z=0.
REQ-027 SHALL cover: ADD, A=0x7F, B=0x01 -> 0x80; after the edge flag_v=1, flag_n=1, flag_c=0.
REQ-028 SHALL cover: SUB, A=5, B=10 -> 251, flag_c=1 (borrow); SUB, A=10, B=10 -> 0, flag_z=1.
REQ-029 SHALL cover: AND/OR/XOR/NOR with A=0x0F, B=0x3C -> 0x0C / 0x3F / 0x33 / 0xC0; unrecognised OP 111111 -> 0x00.
REQ-030 SHALL cover: SRA with A=0x90: B=2 -> 0xE4, B=10 -> 0xFF; SRL with A=0x90: B=2 -> 0x24, B=10 -> 0x00.
REQ-031 SHALL cover: rst_n low mid-cycle after an overflowing ADD -> all flags 0 before the next edge; ALU_Result still correct.
